dmem_responder: RTL and testbench

//   Data-memory target answering the core's load/store port over a valid/ready

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory target for the core's load/store port: valid/ready request and
// response handshakes, programmable wait states, error response on bad addresses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SIZE_BYTES = 32'(4 * DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   off;
  logic          addr_err;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          mem_we;

  always_comb begin
    // Range checked against BASE_ADDR before the offset is trusted, so no wrap.
    off      = addr_q - BASE_ADDR;
    addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || (off >= SIZE_BYTES);
    idx      = off[AW+1:2];
    rd_word  = mem_q[idx];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          // Counter loaded with the full wait count so resp_valid rises
          // WAIT_CYCLES+1 edges after the accept edge, WAIT_CYCLES==0 included.
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = addr_err;
          resp_rdata_d = (!we_q && !addr_err) ? rd_word : '0;
          mem_we       = we_q && !addr_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus random traffic against a
// word-array reference model, on a 2-wait-state and a zero-wait-state instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS((g == 0) ? 1024 : 64),
      .WAIT_CYCLES((g == 0) ? 2 : 0),
      .BASE_ADDR  ((g == 0) ? 32'h0 : 32'h1000)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] model [int];

  function automatic longint base_of(input int d);
    return (d == 0) ? 64'h0 : 64'h1000;
  endfunction
  function automatic longint depth_of(input int d);
    return (d == 0) ? 1024 : 64;
  endfunction
  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // One full transaction: accept, latency, response contents, optional
  // backpressure hold with ignored requests, handshake and bubble.
  task automatic txn(input int d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     output logic [31:0] rdata);
    longint a, lo, hi;
    int key, edges;
    bit exp_err;
    logic [31:0] exp_rd, cur;
    logic [31:0] h_rd;
    logic h_err;
    a  = longint'(addr);
    lo = base_of(d);
    hi = lo + 4 * depth_of(d);
    exp_err = (a % 4 != 0) || (a < lo) || (a >= hi);
    exp_rd  = '0;
    if (!exp_err) begin
      key = d * (1 << 20) + int'((a - lo) / 4);
      if (we) begin
        cur = model.exists(key) ? model[key] : '0;
        for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
        model[key] = cur;
      end else begin
        exp_rd = model[key];
      end
    end

    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be;
    check("req_ready_idle", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    edges = 0;
    while (!resp_valid[d] && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check("latency", 32'(edges), 32'(wait_of(d) + 1));
    check("rdata", resp_rdata[d], exp_rd);
    check("err", 32'(resp_err[d]), 32'(exp_err));
    rdata = resp_rdata[d];
    h_rd  = resp_rdata[d];
    h_err = resp_err[d];

    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = lo[31:0];
      req_wdata[d] = $urandom; req_be[d] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[d]), 32'd1);
      check("hold_rdata", resp_rdata[d], h_rd);
      check("hold_err", 32'(resp_err[d]), 32'(h_err));
      check("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check("hs_valid", 32'(resp_valid[d]), 32'd0);
    check("hs_ready", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a32;
    int acc;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      check("rst_rdata", resp_rdata[d], 32'd0);
      check("rst_err", 32'(resp_err[d]), 32'd0);
      check("rst_req_ready", 32'(req_ready[d]), 32'd1);
      rst[d] = 1'b0;
    end

    // Known contents for every word the random phase may load.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++)
        txn(d, 1'b1, 32'(base_of(d) + 4 * k), $urandom, 4'hF, 0, rd);
      txn(d, 1'b1, 32'(base_of(d) + 4 * (depth_of(d) - 1)), $urandom, 4'hF, 0, rd);
    end

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check("t1_load", rd, 32'hDEADBEEF);

    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd);
    check("t2_partial", rd, 32'h11BB33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    check("be0_noop", rd, 32'h11BB33DD);

    txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, rd);
    txn(0, 1'b1, 32'h12, 32'h55555555, 4'hF, 0, rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check("t3_misaligned_store", rd, 32'hDEADBEEF);
    txn(1, 1'b0, 32'hFFC, 32'h0, 4'h0, 0, rd);
    txn(1, 1'b0, 32'h1100, 32'h0, 4'h0, 0, rd);

    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd);
    txn(1, 1'b0, 32'h1004, 32'h0, 4'h0, 5, rd);

    // Reset while a store sits in BUSY: response dropped, store lost.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10;
    req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    #1;
    check("rst_mid_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_mid_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    rst[0] = 1'b0;
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check("t6_store_lost", rd, 32'hDEADBEEF);

    // Zero-wait throughput with both sides always willing.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h1000; resp_ready[1] = 1'b1;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      if (req_ready[1]) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    resp_ready[1] = 1'b0;
    check("t5_throughput", 32'(acc), 32'd10);

    for (int i = 0; i < 120; i++) begin
      int d, k;
      d = i % 2;
      k = int'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0: a32 = 32'(base_of(d) + 4 * k + $urandom_range(1, 3));
        1: a32 = 32'(base_of(d) + 4 * depth_of(d));
        2: a32 = 32'(base_of(d) - 4);
        3: a32 = 32'(base_of(d) + 4 * (depth_of(d) - 1));
        default: a32 = 32'(base_of(d) + 4 * k);
      endcase
      txn(d, 1'($urandom), a32, $urandom, 4'($urandom), int'($urandom_range(0, 2)), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
